pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator for the CPU fetch stage; successor to the single-register PC.
//  Selects the next PC from several sources: sequential, branch, jump, exception vector, ERET return.
//  Applies a fixed priority between those sources.
//  Buffers a redirect that arrives during a stall and applies it on resume; one PC is issued per enabled cycle.
// PARAMETERS
//  WIDTH      32            PC width in bits
//  RESET_VEC  32'h0000_0000 PC value after reset
//  EXC_VEC    32'h0000_0004 exception entry address
//  INC        4             sequential increment (bytes)
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  ena         in   1      1 = advance PC; 0 = stall (hold pc_out)
//  br_taken    in   1      branch redirect request
//  br_target   in   WIDTH  branch target
//  jmp         in   1      jump redirect request (J/JAL/JR/JALR)
//  jmp_target  in   WIDTH  jump target
//  exc_req     in   1      exception entry (SYSCALL/BREAK/TEQ/...)
//  eret        in   1      return from exception
//  epc_in      in   WIDTH  EPC value from CP0, used by eret
//  pc_out      out  WIDTH  current fetch PC
//  pc_plus     out  WIDTH  pc_out + INC, combinational, wraps mod 2^WIDTH
//  pc_valid    out  1      pc_out is a fetchable address
//  redir_pend  out  1      redirect buffered during stall
// BEHAVIOUR
//  Reset:
//   - rst=1 at edge -> pc_out=RESET_VEC, pc_valid=0, redir_pend=0, state=BOOT.
//   - Reset overrides every other input, including mid-stall and a pending redirect (buffer cleared).
//  Next-PC priority: exc_req > eret > jmp > br_taken > sequential(pc_out+INC).
//  FSM, 3 states:
//   - BOOT: one cycle; next edge -> RUN with pc_valid=1 and pc_out still RESET_VEC (first fetch at reset vector).
//   - RUN, ena=1: pc_out <= selected next PC (1-cycle latency; redirect visible the edge after request).
//   - RUN, ena=0, no request: hold pc_out.
//   - RUN, ena=0, any request: latch highest-priority target into buffer, redir_pend=1, -> HOLD.
//   - HOLD, ena=0: hold. A new request of strictly higher priority overwrites the buffer; equal/lower is ignored.
//   - HOLD, ena=1: pc_out <= buffered target, redir_pend=0, -> RUN.
//     A live exc_req in that cycle beats the buffer (goes to EXC_VEC); other live requests are dropped.
//  Simultaneous requests resolve by priority; losers are discarded (not queued).
//  Arithmetic: pc_plus and sequential next = pc_out + INC truncated to WIDTH (2^WIDTH-4 -> 0 wraps silently).
//  pc_valid=1 in RUN and HOLD, 0 only in BOOT / reset.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN:
//   - Defined: adds output addr_err (1 bit, reset 0).
//   - A selected jmp/br/eret target with low 2 bits != 0 is replaced by EXC_VEC.
//   - addr_err pulses high for exactly one cycle with the redirect (applied or buffered-then-applied).
//   - Undefined: no addr_err port; targets used unmodified.
// STRUCTURE
//  Shared header cpu_defs: FSM state encodings (BOOT/RUN/HOLD), source-priority codes, default vectors.
//  One sub-module, pc_redirect_buf: holds target + priority code + valid, implements the overwrite-if-higher rule.
//  Next-PC mux and FSM stay in pc_gen.
// TESTING
//  1 rst 2 cycles, release -> BOOT 1 cycle (pc_valid=0), then pc_out=0, pc_valid=1; next 3 edges give 4, 8, C.
//  2 pc_out=0x10, br_taken=1 br_target=0x100 and jmp=1 jmp_target=0x200 same cycle -> pc_out=0x200.
//  3 ena=0 at pc_out=0x20, br_taken=1 target=0x80 one cycle -> pc_out stays 0x20, redir_pend=1.
//    Then exc_req while stalled -> buffer=EXC_VEC. Then ena=1 -> pc_out=0x4, redir_pend=0.
//  4 pc_out=0xFFFF_FFFC, ena=1, no request -> pc_out=0x0 (wrap), pc_plus=0x4.
//  5 HOLD with buffered jmp 0x300, assert rst -> pc_out=RESET_VEC, redir_pend=0, pc_valid=0 next cycle.
//  6 [PC_ALIGN_CHECK_EN] jmp_target=0x102 -> pc_out=0x4, addr_err=1 one cycle; undefined build -> pc_out=0x102.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: FSM state encodings, redirect-source priority codes and default vectors for pc_gen
package pc_gen_pkg;
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  typedef enum logic [2:0] {PRI_NONE, PRI_BR, PRI_JMP, PRI_ERET, PRI_EXC} pri_e;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC = 32'h0000_0004;
  localparam int DEF_INC = 4;
  function automatic logic is_target_src(pri_e p);
    return p == PRI_BR || p == PRI_JMP || p == PRI_ERET;
  endfunction
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds one stalled redirect; a request replaces it only if strictly higher priority
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  pri_e             req_pri,
  input  logic [WIDTH-1:0] req_tgt,
  output logic             valid,
  output pri_e             pri,
  output logic [WIDTH-1:0] tgt
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid <= 1'b0;
      pri <= PRI_NONE;
      tgt <= '0;
    end else if (req_pri > pri) begin
      valid <= 1'b1;
      pri <= req_pri;
      tgt <= req_tgt;
    end
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with prioritised redirects and stall buffering.
// Optional PC_ALIGN_CHECK_EN adds addr_err and diverts misaligned targets to EXC_VEC.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int               INC       = DEF_INC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus,
  output logic             pc_valid,
  output logic             redir_pend
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             addr_err
`endif
);
  logic [1:0] state;
  pri_e live_pri, buf_pri, app_pri, buf_req;
  logic [WIDTH-1:0] live_tgt, buf_tgt, app_tgt, app_pc, next_pc;
  logic active, use_buf, buf_clr;
  assign active = state != ST_BOOT;
  assign use_buf = state == ST_HOLD && !exc_req;
  assign buf_clr = state == ST_HOLD && ena;
  always_comb begin
    live_pri = exc_req ? PRI_EXC : eret ? PRI_ERET : jmp ? PRI_JMP : br_taken ? PRI_BR : PRI_NONE;
    live_tgt = exc_req ? EXC_VEC : eret ? epc_in : jmp ? jmp_target : br_target;
    app_pri = use_buf ? buf_pri : live_pri;
    app_tgt = use_buf ? buf_tgt : live_tgt;
    buf_req = active && !ena ? live_pri : PRI_NONE;
  end
`ifdef PC_ALIGN_CHECK_EN
  logic app_err;
  assign app_err = is_target_src(app_pri) && app_tgt[1:0] != 2'b00;
  assign app_pc = app_err ? EXC_VEC : app_tgt;
  always_ff @(posedge clk) addr_err <= rst ? 1'b0 : active && ena && app_err;
`else
  assign app_pc = app_tgt;
`endif
  assign pc_plus = pc_out + WIDTH'(INC);
  assign next_pc = app_pri == PRI_NONE ? pc_plus : app_pc;
  assign pc_valid = active;
  pc_redirect_buf #(.WIDTH(WIDTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .req_pri (buf_req),
    .req_tgt (live_tgt),
    .valid   (redir_pend),
    .pri     (buf_pri),
    .tgt     (buf_tgt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BOOT;
      pc_out <= RESET_VEC;
    end else begin
      state <= !active || ena ? ST_RUN : (state == ST_HOLD || live_pri != PRI_NONE) ? ST_HOLD : ST_RUN;
      if (active && ena) pc_out <= next_pc;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized traffic checked every cycle against a behavioural model
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst, ena, br_taken, jmp, exc_req, eret;
  logic [31:0] br_target, jmp_target, epc_in;
  logic [31:0] pc_out, pc_plus;
  logic pc_valid, redir_pend;
`ifdef PC_ALIGN_CHECK_EN
  logic addr_err;
`endif
  int n_chk = 0, n_pass = 0;
  bit chk_on = 0;
  logic [31:0] m_pc, m_btgt;
  bit m_booted, m_pend;
  int m_bpri;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .ena(ena), .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target), .exc_req(exc_req), .eret(eret), .epc_in(epc_in),
    .pc_out(pc_out), .pc_plus(pc_plus), .pc_valid(pc_valid), .redir_pend(redir_pend)
`ifdef PC_ALIGN_CHECK_EN
    , .addr_err(addr_err)
`endif
  );

  always @(posedge clk) begin
    int req;
    logic [31:0] tgt;
    req = exc_req ? 4 : eret ? 3 : jmp ? 2 : br_taken ? 1 : 0;
    tgt = exc_req ? 32'h4 : eret ? epc_in : jmp ? jmp_target : br_target;
    if (rst) begin
      m_pc = 32'h0; m_booted = 0; m_pend = 0; m_bpri = 0;
    end else if (!m_booted) m_booted = 1;
    else if (ena) begin
      if (m_pend) m_pc = exc_req ? 32'h4 : m_btgt;
      else m_pc = req != 0 ? tgt : m_pc + 32'd4;
      m_pend = 0; m_bpri = 0;
    end else if (req > m_bpri) begin
      m_pend = 1; m_bpri = req; m_btgt = tgt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("model_pc_out", pc_out, m_pc);
    chk("model_pc_plus", pc_plus, m_pc + 32'd4);
    chk("model_pc_valid", {31'b0, pc_valid}, {31'b0, m_booted});
    chk("model_redir_pend", {31'b0, redir_pend}, {31'b0, m_pend});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    br_taken = 0; jmp = 0; exc_req = 0; eret = 0;
  endtask

  initial begin
    rst = 1; ena = 1; idle();
    br_target = 0; jmp_target = 0; epc_in = 0;
    cyc();
    chk_on = 1;
    cyc();
    chk("rst_valid", {31'b0, pc_valid}, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_pend", {31'b0, redir_pend}, 32'h0);
    rst = 0;
    cyc();
    chk("boot_pc", pc_out, 32'h0);
    chk("boot_valid", {31'b0, pc_valid}, 32'h1);
    cyc(); chk("seq_4", pc_out, 32'h4);
    cyc(); chk("seq_8", pc_out, 32'h8);
    cyc(); chk("seq_c", pc_out, 32'hC);
    cyc(); chk("seq_10", pc_out, 32'h10);
    br_taken = 1; br_target = 32'h100; jmp = 1; jmp_target = 32'h200;
    cyc(); idle();
    chk("jmp_beats_br", pc_out, 32'h200);
    jmp = 1; jmp_target = 32'h20;
    cyc(); idle();
    chk("at_20", pc_out, 32'h20);
    ena = 0; br_taken = 1; br_target = 32'h80;
    cyc(); idle();
    chk("stall_hold", pc_out, 32'h20);
    chk("stall_pend", {31'b0, redir_pend}, 32'h1);
    exc_req = 1;
    cyc(); idle();
    chk("stall_exc_hold", pc_out, 32'h20);
    ena = 1;
    cyc();
    chk("resume_exc", pc_out, 32'h4);
    chk("resume_pend", {31'b0, redir_pend}, 32'h0);
    jmp = 1; jmp_target = 32'hFFFF_FFFC;
    cyc(); idle();
    chk("top_pc", pc_out, 32'hFFFF_FFFC);
    chk("top_plus", pc_plus, 32'h0);
    cyc();
    chk("wrap_pc", pc_out, 32'h0);
    chk("wrap_plus", pc_plus, 32'h4);
    ena = 0; jmp = 1; jmp_target = 32'h40;
    cyc(); idle();
    br_taken = 1; br_target = 32'h50;
    cyc(); idle();
    jmp = 1; jmp_target = 32'h60;
    cyc(); idle();
    ena = 1;
    cyc();
    chk("hold_keeps_first", pc_out, 32'h40);
    ena = 0; jmp = 1; jmp_target = 32'h300;
    cyc(); idle();
    chk("hold_300_pend", {31'b0, redir_pend}, 32'h1);
    rst = 1;
    cyc();
    chk("rst_hold_pc", pc_out, 32'h0);
    chk("rst_hold_pend", {31'b0, redir_pend}, 32'h0);
    chk("rst_hold_valid", {31'b0, pc_valid}, 32'h0);
    rst = 0; ena = 1;
    cyc();
`ifdef PC_ALIGN_CHECK_EN
    jmp = 1; jmp_target = 32'h102;
    cyc(); idle();
    chk("misalign_pc", pc_out, 32'h4);
    chk("misalign_err", {31'b0, addr_err}, 32'h1);
    cyc();
    chk("misalign_err_drop", {31'b0, addr_err}, 32'h0);
`else
    jmp = 1; jmp_target = 32'h102;
    cyc(); idle();
    chk("unaligned_pc", pc_out, 32'h102);
`endif
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] mask;
`ifdef PC_ALIGN_CHECK_EN
      mask = 32'hFFFF_FFFC;
`else
      mask = 32'hFFFF_FFFF;
`endif
      rst = $urandom_range(0, 99) == 0;
      ena = $urandom_range(0, 3) != 0;
      br_taken = $urandom_range(0, 4) == 0;
      jmp = $urandom_range(0, 5) == 0;
      eret = $urandom_range(0, 9) == 0;
      exc_req = $urandom_range(0, 11) == 0;
      br_target = $urandom & mask;
      jmp_target = $urandom & mask;
      epc_in = $urandom & mask;
      cyc();
    end
    rst = 0; idle();
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
